// File: rtl/cla_seq_adder_ctrl.sv
// rtl/cla_seq_adder_ctrl.sv - nibble-serial adder controller around one 4-bit carry-lookahead slice

// 4-bit carry-lookahead slice: full lookahead carries, c3 exposed for overflow.
module cla_slice4 (
    input  logic [3:0] x_i,
    input  logic [3:0] y_i,
    input  logic       c0_i,
    output logic [3:0] s_o,
    output logic       c3_o,
    output logic       c4_o
);

    logic [3:0] p;
    logic [3:0] g;
    logic       c1;
    logic       c2;
    logic       c3;
    logic       c4;

    // Propagate/generate terms and flat lookahead carries, no ripple between bits.
    always_comb begin
        p  = x_i ^ y_i;
        g  = x_i & y_i;
        c1 = g[0] | (p[0] & c0_i);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0_i);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & c0_i);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & c0_i);
        s_o  = p ^ {c3, c2, c1, c0_i};
        c3_o = c3;
        c4_o = c4;
    end

endmodule

// Sequencer: accepts operands, adds one nibble per cycle LSB first, then holds the result.
module cla_seq_adder_ctrl #(
    parameter int WIDTH  = 16,
    parameter int NSLICE = WIDTH / 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // A single-nibble adder still needs one index bit so the register is never zero-width.
    localparam int IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   opa_q;
    logic [WIDTH-1:0]   opb_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;
    logic [WIDTH-1:0]   res_q;
    logic [WIDTH-1:0]   res_d;
    logic               cout_q;
    logic               ovf_q;
    logic               in_ready_q;
    logic               out_valid_q;

    logic [3:0]         x_nib;
    logic [3:0]         y_nib;
    logic [3:0]         s_nib;
    logic               c3_nib;
    logic               c4_nib;
    logic               last_nib;

    cla_slice4 u_slice (
        .x_i  (x_nib),
        .y_i  (y_nib),
        .c0_i (carry_q),
        .s_o  (s_nib),
        .c3_o (c3_nib),
        .c4_o (c4_nib)
    );

    // Steer the current nibble into the slice and merge its sum back into the result word.
    always_comb begin
        x_nib = 4'h0;
        y_nib = 4'h0;
        res_d = res_q;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx_q == IDX_W'(i)) begin
                x_nib            = opa_q[4*i +: 4];
                y_nib            = opb_q[4*i +: 4];
                res_d[4*i +: 4]  = s_nib;
            end
        end
        last_nib = (idx_q == IDX_W'(NSLICE - 1));
    end

    // Controller FSM with handshake outputs registered alongside the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            opa_q       <= '0;
            opb_q       <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            res_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        opa_q      <= a;
                        opb_q      <= b;
                        carry_q    <= cin;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    res_q   <= res_d;
                    carry_q <= c4_nib;
                    idx_q   <= idx_q + IDX_W'(1);
                    if (last_nib) begin
                        cout_q      <= c4_nib;
                        ovf_q       <= c3_nib ^ c4_nib;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = res_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/cla_seq_adder_ctrl.md
# cla_seq_adder_ctrl

Sequencing controller that performs WIDTH-bit addition by time-sharing one 4-bit carry-lookahead slice adder, processing one nibble per clock, LSB first. The slice carry-out is registered between nibbles. It sits between an operand producer and a result consumer, using valid/ready handshakes on both sides. It is the multi-word front end for the 4-bit CLA datapath.

## Interface

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 4.
- NSLICE, WIDTH/4, derived nibble count; do not override.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands a, b, cin present.
- in_ready  output  1  controller can accept operands.
- a  input  WIDTH  addend.
- b  input  WIDTH  addend.
- cin  input  1  carry-in to bit 0.
- out_valid  output  1  result valid and stable.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  registered result.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow: carry into the MSB XOR cout.

## Operation

- Internal slice adder: 4-bit CLA with p = x^y, g = x&y, c1..c4 from full lookahead equations, and sum = p ^ {c3,c2,c1,c0}. It also exposes c3 for overflow detection. Purely combinational.
- Registers:
  - opa/opb (WIDTH)
  - carry (1)
  - idx (ceil(log2 NSLICE), minimum 1 bit)
  - res (WIDTH)
  - cout_r
  - ovf_r
  - state
- States: IDLE, ADD, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch a→opa, b→opb, cin→carry; set idx ← 0; go to ADD.
- ADD:
  - in_ready = 0.
  - Slice inputs: opa[4*idx+:4], opb[4*idx+:4], carry.
  - Each cycle: res[4*idx+:4] ← slice sum, carry ← c4, idx ← idx+1.
  - When idx == NSLICE-1: also cout_r ← c4, ovf_r ← c3 ^ c4, and go to DONE.
- DONE:
  - out_valid = 1; sum = res, cout = cout_r, ovf = ovf_r, all held stable.
  - On out_ready: go to IDLE.
- in_ready and out_valid are decoded from state only. There is no combinational path from any input to any output.
- a, b and cin are sampled only at the accept edge. Later changes have no effect on the operation in flight.
- in_valid in ADD/DONE is ignored and not queued; the producer holds it until in_ready.
- out_ready outside DONE is ignored.
- res, cout_r and ovf_r keep the last result after leaving DONE. They are overwritten nibble by nibble during the next ADD.
- Arithmetic is unsigned modulo 2^WIDTH for sum. ovf is valid for a two's-complement interpretation.

## Timing

- Reset (reset_n low, asynchronous):
  - state = IDLE, idx = 0, carry = 0.
  - res, cout_r, ovf_r = 0.
  - Outputs during and after reset: in_ready = 1, out_valid = 0, sum = 0, cout = 0, ovf = 0.
- Reset mid-ADD or mid-DONE abandons the operation immediately; no partial result is presented.
- Latency: accept at edge E0; ADD occupies edges E1..E(NSLICE); out_valid rises after E(NSLICE). Default is 4 cycles.
- With out_ready already high in DONE, the handshake completes at E(NSLICE+1) and in_ready rises after it.
- Minimum issue interval is NSLICE+2 cycles (6 at default).
- out_ready held low keeps DONE indefinitely, with outputs unchanged.
- Slice adder settling, including modeled gate delays (up to 10 ns carry + 3 ns sum), must fit in one period. The bench uses a 20 ns period.
- WIDTH = 4: a single ADD cycle, and c3/c4 come from that slice.

## Test plan

- Basic add: WIDTH=16, a=0x1234, b=0x4321, cin=0, out_ready=1 → out_valid high exactly 4 cycles after the accept edge; sum=0x5555, cout=0, ovf=0; in_ready returns 1 cycle after the out handshake.
- Full ripple: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. Also a=0x0000, b=0x0000, cin=1 → sum=0x0001, cout=0.
- Signed overflow: a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1. And a=0x8000, b=0x8000 → sum=0x0000, cout=1, ovf=1.
- Backpressure and ignored input:
  - Hold out_ready=0 for 5 cycles in DONE → sum/cout/ovf/out_valid constant.
  - Pulse in_valid with new operands during ADD and DONE → no effect on the result; in_ready stays 0.
  - Change a/b after accept → no effect.
- Reset mid-operation: assert reset_n=0 asynchronously (between edges) during the 2nd ADD cycle → outputs immediately at reset values. After release, in_ready=1, out_valid=0; the next operation (0x00FF+0x0001 → 0x0100) is correct.
- Parameter sweep: WIDTH=4, a=0xF, b=0x1 → sum=0x0, cout=1, ovf=0, latency 1 cycle. WIDTH=32, a=0xFFFFFFFF, b=0x00000001 → sum=0, cout=1, latency 8 cycles.
